// File: rtl/ntt_stage_ctrl.sv
// Stage sequencer for the in-place NTT: issues one read per row per stage and the matching
// write-back PIPE_LAT cycles later, holding off the next stage until the last write lands.
module ntt_stage_ctrl #(
   parameter int unsigned MA        = 16,
   parameter int unsigned STAGE_NUM = 8,
   parameter int unsigned PIPE_LAT  = 6,
   parameter int unsigned AW        = $clog2(MA),
   parameter int unsigned SW        = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          hold,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [SW-1:0] stage,
   output logic          tf_stage_start
);

   localparam logic [AW-1:0] RowLast   = AW'(MA - 1);
   localparam logic [SW-1:0] StageLast = SW'(STAGE_NUM - 1);

   typedef enum logic [1:0] {StIdle, StRd, StDrain, StFin} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] row_q, row_d;
   logic [SW-1:0] stage_q, stage_d;

   logic [PIPE_LAT-1:0] pvld_q;
   logic [AW-1:0]       paddr_q [PIPE_LAT];

   logic last_wr;

   // The stage's last write leaving the pipeline is what releases the next stage's reads.
   assign last_wr = pvld_q[PIPE_LAT-1] && (paddr_q[PIPE_LAT-1] == RowLast);

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      stage_d        = stage_q;
      busy           = 1'b0;
      done           = 1'b0;
      rd_en          = 1'b0;
      rd_addr        = '0;
      tf_stage_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRd;
               row_d   = '0;
               stage_d = '0;
            end
         end
         StRd: begin
            busy    = 1'b1;
            rd_addr = row_q;
            if (!hold) begin
               rd_en          = 1'b1;
               tf_stage_start = (row_q == '0);
               if (row_q == RowLast) begin
                  row_d   = '0;
                  state_d = StDrain;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         StDrain: begin
            busy = 1'b1;
            if (last_wr) begin
               if (stage_q == StageLast) begin
                  state_d = StFin;
               end else begin
                  stage_d = stage_q + 1'b1;
                  state_d = StRd;
               end
            end
         end
         StFin: begin
            busy    = 1'b1;
            done    = 1'b1;
            stage_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_en   = pvld_q[PIPE_LAT-1];
   assign wr_addr = pvld_q[PIPE_LAT-1] ? paddr_q[PIPE_LAT-1] : '0;
   assign stage   = stage_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         row_q   <= '0;
         stage_q <= '0;
         pvld_q  <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         stage_q   <= stage_d;
         pvld_q[0] <= rd_en;
         for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            pvld_q[i] <= pvld_q[i-1];
         end
      end
   end

   // Addresses only matter alongside a valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      paddr_q[0] <= rd_addr;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
         paddr_q[i] <= paddr_q[i-1];
      end
   end

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: expected read/write/done events are generated from the
// stage timing rules when start is driven, and popped as the DUT produces them.
module tb_ntt_stage_ctrl;

   localparam int MA = 16;
   localparam int SN = 8;
   localparam int PL = 6;
   localparam int AW = 4;
   localparam int SW = 3;
   localparam int NEVER = 32'h7fff_ffff;

   typedef struct {
      int c;
      int a;
      int tf;
      int s;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst, start, hold;
   logic          busy, done, rd_en, wr_en, tf_stage_start;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [SW-1:0] stage;

   logic e_rst, e_start, e_hold;
   logic e_busy, e_done, e_rd_en, e_wr_en, e_tf;
   logic e_rd_addr, e_wr_addr, e_stage;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_rd  = 0;
   int n_wr  = 0;

   ev_t rd_q[$];
   ev_t wr_q[$];
   int  done_q[$];

   ntt_stage_ctrl #(.MA(MA), .STAGE_NUM(SN), .PIPE_LAT(PL)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .stage(stage),
      .tf_stage_start(tf_stage_start)
   );

   ntt_stage_ctrl #(.MA(2), .STAGE_NUM(1), .PIPE_LAT(1)) dut_edge (
      .clk(clk), .rst(e_rst), .start(e_start), .hold(e_hold), .busy(e_busy), .done(e_done),
      .rd_en(e_rd_en), .rd_addr(e_rd_addr), .wr_en(e_wr_en), .wr_addr(e_wr_addr),
      .stage(e_stage), .tf_stage_start(e_tf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   // Expected event stream for one transform started at absolute cycle base; hold is high for
   // relative cycles lo..hi; nothing after absolute cycle cutoff is expected (reset).
   task automatic push_model(input int base, input int lo, input int hi, input int cutoff);
      int  t;
      ev_t e;
      t = base + 1;
      for (int s = 0; s < SN; s++) begin
         for (int r = 0; r < MA; r++) begin
            while ((t - base) >= lo && (t - base) <= hi) t++;
            if (t <= cutoff) begin
               e = '{c: t, a: r, tf: (r == 0) ? 1 : 0, s: s};
               rd_q.push_back(e);
            end
            if (t + PL <= cutoff) begin
               e = '{c: t + PL, a: r, tf: 0, s: s};
               wr_q.push_back(e);
            end
            t++;
         end
         t = t - 1 + PL + 1;
      end
      if (t <= cutoff) done_q.push_back(t);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (rd_en) begin
         n_rd++;
         if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
         else begin
            e = rd_q.pop_front();
            check("rd_cycle", cyc, e.c);
            check("rd_addr", int'(rd_addr), e.a);
            check("tf_stage_start", int'(tf_stage_start), e.tf);
            check("rd_stage", int'(stage), e.s);
         end
      end else if (tf_stage_start) begin
         check("tf_without_rd", 1, 0);
      end
      if (wr_en) begin
         n_wr++;
         if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
         else begin
            e = wr_q.pop_front();
            check("wr_cycle", cyc, e.c);
            check("wr_addr", int'(wr_addr), e.a);
         end
      end
      if (done) begin
         if (done_q.size() == 0) check("done_unexpected", 1, 0);
         else begin
            check("done_cycle", cyc, done_q.pop_front());
            check("busy_at_done", int'(busy), 1);
         end
      end
   end

   // One run: start at rc 0, optional hold window, extra starts, reset and restart; a spot check
   // of busy/stage/rd_en/wr_en at rc chk.
   task automatic run_case(input int lo, input int hi, input int xs1, input int xs2,
                           input int rst_rc, input int rs_rc, input int chk, input int cb,
                           input int cs, input int n);
      int t0;
      t0   = 0;
      n_rd = 0;
      n_wr = 0;
      for (int rc = 0; rc < n; rc++) begin
         @(posedge clk);
         #1;
         if (rc == 0) begin
            t0 = cyc;
            push_model(t0, lo, hi, (rst_rc >= 0) ? t0 + rst_rc : NEVER);
         end
         if (rc == rs_rc) push_model(t0 + rs_rc, -1, -1, NEVER);
         start = (rc == 0 || rc == xs1 || rc == xs2 || rc == rs_rc);
         hold  = (rc >= lo && rc <= hi);
         rst   = (rc == rst_rc);
         @(negedge clk);
         if (rc == 1) check("busy_after_start", int'(busy), 1);
         if (rc == chk) begin
            check("pt_busy", int'(busy), cb);
            check("pt_stage", int'(stage), cs);
            check("pt_rd_en", int'(rd_en), 0);
            check("pt_wr_en", int'(wr_en), 0);
            check("pt_done", int'(done), 0);
         end
      end
      check("rd_left", rd_q.size(), 0);
      check("wr_left", wr_q.size(), 0);
      check("done_left", done_q.size(), 0);
      check("busy_end", int'(busy), 0);
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      hold    = 1'b0;
      e_rst   = 1'b1;
      e_start = 1'b0;
      e_hold  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst   = 1'b0;
      e_rst = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rd_en", int'(rd_en), 0);
      check("rst_rd_addr", int'(rd_addr), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_stage", int'(stage), 0);
      check("rst_tf", int'(tf_stage_start), 0);

      // Basic run, then the read/write totals.
      run_case(-1, -1, -1, -1, -1, -1, -1, 0, 0, 190);
      check("total_reads", n_rd, MA * SN);
      check("total_writes", n_wr, MA * SN);
      // Hold in mid-stage, relative cycles 5..7.
      run_case(5, 7, -1, -1, -1, -1, -1, 0, 0, 190);
      // Hold on the first read of stage 1; stage already 1 in the held cycle.
      run_case(23, 23, -1, -1, -1, -1, 23, 1, 1, 190);
      // Start pulses while busy are ignored.
      run_case(-1, -1, 10, 100, -1, -1, -1, 0, 0, 190);
      // Reset at 30, idle at 31, restart at 40.
      run_case(-1, -1, -1, -1, 30, 40, 31, 0, 0, 235);

      // Edge parameters: MA=2, STAGE_NUM=1, PIPE_LAT=1.
      for (int rc = 0; rc < 7; rc++) begin
         @(posedge clk);
         #1;
         e_start = (rc == 0);
         @(negedge clk);
         check("edge_rd_en", int'(e_rd_en), (rc == 1 || rc == 2) ? 1 : 0);
         check("edge_rd_addr", int'(e_rd_addr), (rc == 2) ? 1 : 0);
         check("edge_wr_en", int'(e_wr_en), (rc == 2 || rc == 3) ? 1 : 0);
         check("edge_wr_addr", int'(e_wr_addr), (rc == 3) ? 1 : 0);
         check("edge_done", int'(e_done), (rc == 4) ? 1 : 0);
         check("edge_busy", int'(e_busy), (rc >= 1 && rc <= 4) ? 1 : 0);
         check("edge_tf", int'(e_tf), (rc == 1) ? 1 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
